// File: rtl/mem_channel_responder.sv
// Multi-channel memory responder: independent per-channel read and write FSMs with a
// fixed request-to-ready latency, all sharing one storage array, plus a preload port.
module mem_channel_responder #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load_en,
    input  logic [ADDR_BITS-1:0]                   load_addr,
    input  logic [DATA_BITS-1:0]                   load_data,
    input  logic [NUM_CHANNELS-1:0]                read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]                read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]                write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]                write_ready
);
    localparam int unsigned CNT_BITS = 4;
    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_channel_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } chan_state_e;

    logic [DATA_BITS-1:0]    mem [DEPTH];
    logic [NUM_CHANNELS-1:0] wr_commit;
    logic [ADDR_BITS-1:0]    wr_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_word [NUM_CHANNELS];

    // Array is never reset; later loop iterations win, so the highest channel beats lower ones and load.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            if (wr_commit[i]) begin
                mem[wr_addr[i]] <= wr_word[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_chan
        chan_state_e          rd_state_q, rd_state_d;
        logic [CNT_BITS-1:0]  rd_cnt_q, rd_cnt_d;
        logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
        logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
        logic                 rd_ready_q, rd_ready_d;

        chan_state_e          wr_state_q, wr_state_d;
        logic [CNT_BITS-1:0]  wr_cnt_q, wr_cnt_d;
        logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
        logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
        logic                 wr_ready_q, wr_ready_d;
        logic                 wr_commit_c;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_state_q <= ST_IDLE;
                rd_cnt_q   <= '0;
                rd_addr_q  <= '0;
                rd_data_q  <= '0;
                rd_ready_q <= 1'b0;
                wr_state_q <= ST_IDLE;
                wr_cnt_q   <= '0;
                wr_addr_q  <= '0;
                wr_data_q  <= '0;
                wr_ready_q <= 1'b0;
            end else begin
                rd_state_q <= rd_state_d;
                rd_cnt_q   <= rd_cnt_d;
                rd_addr_q  <= rd_addr_d;
                rd_data_q  <= rd_data_d;
                rd_ready_q <= rd_ready_d;
                wr_state_q <= wr_state_d;
                wr_cnt_q   <= wr_cnt_d;
                wr_addr_q  <= wr_addr_d;
                wr_data_q  <= wr_data_d;
                wr_ready_q <= wr_ready_d;
            end
        end

        // Read FSM; the array read sees pre-edge contents, so a colliding write returns the old word.
        always_comb begin
            rd_state_d = rd_state_q;
            rd_cnt_d   = rd_cnt_q;
            rd_addr_d  = rd_addr_q;
            rd_data_d  = rd_data_q;
            rd_ready_d = rd_ready_q;
            case (rd_state_q)
                ST_IDLE: begin
                    if (read_valid[g]) begin
                        rd_addr_d  = read_address[g];
                        rd_cnt_d   = CNT_LOAD;
                        rd_state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_cnt_q == '0) begin
                        rd_data_d  = mem[rd_addr_q];
                        rd_ready_d = 1'b1;
                        rd_state_d = ST_RESP;
                    end else begin
                        rd_cnt_d = rd_cnt_q - CNT_BITS'(1);
                    end
                end
                ST_RESP: begin
                    if (!read_valid[g]) begin
                        rd_ready_d = 1'b0;
                        rd_state_d = ST_IDLE;
                    end
                end
                default: rd_state_d = ST_IDLE;
            endcase
        end

        // Write FSM; the array is only touched at the commit edge, so a reset in WAIT drops the write.
        always_comb begin
            wr_state_d  = wr_state_q;
            wr_cnt_d    = wr_cnt_q;
            wr_addr_d   = wr_addr_q;
            wr_data_d   = wr_data_q;
            wr_ready_d  = wr_ready_q;
            wr_commit_c = 1'b0;
            case (wr_state_q)
                ST_IDLE: begin
                    if (write_valid[g]) begin
                        wr_addr_d  = write_address[g];
                        wr_data_d  = write_data[g];
                        wr_cnt_d   = CNT_LOAD;
                        wr_state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wr_cnt_q == '0) begin
                        wr_commit_c = 1'b1;
                        wr_ready_d  = 1'b1;
                        wr_state_d  = ST_RESP;
                    end else begin
                        wr_cnt_d = wr_cnt_q - CNT_BITS'(1);
                    end
                end
                ST_RESP: begin
                    if (!write_valid[g]) begin
                        wr_ready_d = 1'b0;
                        wr_state_d = ST_IDLE;
                    end
                end
                default: wr_state_d = ST_IDLE;
            endcase
        end

        assign wr_commit[g]   = wr_commit_c;
        assign wr_addr[g]     = wr_addr_q;
        assign wr_word[g]     = wr_data_q;
        assign read_ready[g]  = rd_ready_q;
        assign read_data[g]   = rd_data_q;
        assign write_ready[g] = wr_ready_q;
    end

endmodule

// File: tb/tb_mem_channel_responder.sv
// Directed scoreboard bench for mem_channel_responder with default parameters (LATENCY=2).
module tb_mem_channel_responder;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 2;

    logic                    clk;
    logic                    reset;
    logic                    load_en;
    logic [AW-1:0]           load_addr;
    logic [DW-1:0]           load_data;
    logic [NCH-1:0]          read_valid;
    logic [NCH-1:0][AW-1:0]  read_address;
    logic [NCH-1:0]          read_ready;
    logic [NCH-1:0][DW-1:0]  read_data;
    logic [NCH-1:0]          write_valid;
    logic [NCH-1:0][AW-1:0]  write_address;
    logic [NCH-1:0][DW-1:0]  write_data;
    logic [NCH-1:0]          write_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] sb[$];

    mem_channel_responder #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NCH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic pop_check_rd(input int ch);
        logic [DW-1:0] e;
        e = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        check("rd_ready", 32'(read_ready[ch]), 32'd1);
        check("rd_data", 32'(read_data[ch]), 32'(e));
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] e);
        int lat;
        sb.push_back(e);
        read_address[ch] = a;
        read_valid[ch]   = 1'b1;
        lat = 0;
        do begin step(); lat++; end while (!read_ready[ch] && lat < 20);
        check("rd_latency", 32'(lat), 32'(LAT + 1));
        pop_check_rd(ch);
        read_valid[ch] = 1'b0;
        step();
        check("rd_ready_fall", 32'(read_ready[ch]), 32'd0);
    endtask

    task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        write_address[ch] = a;
        write_data[ch]    = d;
        write_valid[ch]   = 1'b1;
        lat = 0;
        do begin step(); lat++; end while (!write_ready[ch] && lat < 20);
        check("wr_latency", 32'(lat), 32'(LAT + 1));
        write_valid[ch] = 1'b0;
        step();
        check("wr_ready_fall", 32'(write_ready[ch]), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        read_address = '0; write_address = '0; write_data = '0;

        // 1: reset held with every request asserted; preload mem[0] so post-release reads are defined
        read_valid = '1; write_valid = '1;
        load_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_read_ready", 32'(read_ready), 32'd0);
            check("rst_write_ready", 32'(write_ready), 32'd0);
            check("rst_read_data", 32'(read_data), 32'd0);
        end
        load_en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) sb.push_back(8'h00);
        step();
        check("rel_accept_rd", 32'(read_ready), 32'd0);
        step();
        check("rel_wait_wr", 32'(write_ready), 32'd0);
        step();
        check("rel_wr_ready", 32'(write_ready), 32'hF);
        for (int i = 0; i < NCH; i++) pop_check_rd(i);
        read_valid = '0; write_valid = '0;
        step();
        check("rel_rd_fall", 32'(read_ready), 32'd0);
        check("rel_wr_fall", 32'(write_ready), 32'd0);

        // 2: single read with ready held while valid stays high
        load_word(8'h10, 8'hA5);
        sb.push_back(8'hA5);
        read_address[0] = 8'h10; read_valid[0] = 1'b1;
        step();
        check("t2_edge0", 32'(read_ready[0]), 32'd0);
        step();
        check("t2_edge1", 32'(read_ready[0]), 32'd0);
        step();
        pop_check_rd(0);
        read_address[0] = 8'h00;
        step();
        check("t2_hold_ready", 32'(read_ready[0]), 32'd1);
        check("t2_hold_data", 32'(read_data[0]), 32'hA5);
        read_valid[0] = 1'b0;
        step();
        check("t2_fall", 32'(read_ready[0]), 32'd0);
        check("t2_data_kept", 32'(read_data[0]), 32'hA5);

        // 3: write then read on different channels
        do_write(1, 8'h20, 8'h3C);
        do_read(2, 8'h20, 8'h3C);

        // 4: two channels commit to one address in the same edge
        write_address[0] = 8'h40; write_data[0] = 8'h11;
        write_address[3] = 8'h40; write_data[3] = 8'h33;
        write_valid[0] = 1'b1; write_valid[3] = 1'b1;
        step(); step(); step();
        check("t4_ready", 32'(write_ready), 32'h9);
        write_valid = '0;
        step();
        do_read(0, 8'h40, 8'h33);

        // 5: read and write to one address commit together
        do_write(0, 8'h50, 8'h01);
        sb.push_back(8'h01);
        read_address[1] = 8'h50; read_valid[1] = 1'b1;
        write_address[2] = 8'h50; write_data[2] = 8'h02; write_valid[2] = 1'b1;
        step(); step(); step();
        check("t5_wr_ready", 32'(write_ready[2]), 32'd1);
        pop_check_rd(1);
        read_valid[1] = 1'b0; write_valid[2] = 1'b0;
        step();
        do_read(3, 8'h50, 8'h02);

        // 6: reset during the WAIT phase of a write
        do_write(0, 8'h60, 8'h00);
        write_address[1] = 8'h60; write_data[1] = 8'h77; write_valid[1] = 1'b1;
        step();
        #2 reset = 1'b0;
        #1;
        check("t6_async_wr_ready", 32'(write_ready), 32'd0);
        check("t6_async_rd_data", 32'(read_data), 32'd0);
        write_valid[1] = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("t6_idle_a", 32'(write_ready[1]), 32'd0);
        step();
        check("t6_idle_b", 32'(write_ready[1]), 32'd0);
        do_write(1, 8'h61, 8'h12);
        do_read(1, 8'h60, 8'h00);
        do_read(2, 8'h61, 8'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
